// File: rtl/control_velocidad_teclas.sv
// rtl/control_velocidad_teclas.sv - key debounce, speed level and tick generator for the light game
//
// Purpose: synchronises and debounces the two raw active-low push-buttons,
// turns each accepted press into a speed level change, and derives the
// sequencer advance pulse from that level.
// Optional feature macro: CTRL_VEL_WRAP_EN (wrap 7<->0 instead of saturating).
//
// Ports:
//   CLK_50     in   system clock, the only clock
//   RST        in   synchronous active-high reset
//   EN         in   tick enable; 0 holds the tick generator cleared
//   KEY_DEC_N  in   raw decrement button, active-low, asynchronous
//   KEY_INC_N  in   raw increment button, active-low, asynchronous
//   VEL        out  speed level, 0 slowest .. 7 fastest
//   TICK       out  one-cycle sequencer advance pulse
//   PRESS_DEC  out  one-cycle pulse per accepted decrement press
//   PRESS_INC  out  one-cycle pulse per accepted increment press
//   SAT        out  one-cycle pulse when a press is rejected at a limit
module control_velocidad_teclas #(
   parameter int         DEB_CYCLES = 500000,
   parameter int         BASE_DIV   = 3125000,
   parameter logic [2:0] VEL_INIT   = 3'd3
) (
   input  logic       CLK_50,
   input  logic       RST,
   input  logic       EN,
   input  logic       KEY_DEC_N,
   input  logic       KEY_INC_N,
   output logic [2:0] VEL,
   output logic       TICK,
   output logic       PRESS_DEC,
   output logic       PRESS_INC,
   output logic       SAT
);

   localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
   localparam logic [21:0]   PRESC_LAST = 22'(BASE_DIV - 1);

   localparam logic [1:0] ST_RELEASED     = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_PRESSED      = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   // Index 0 is the decrement key, index 1 the increment key.
   logic [1:0]          key_raw;
   logic [1:0]          sync1_q, sync2_q;
   logic [1:0][1:0]     st_q, st_d;
   logic [1:0][CW-1:0]  cnt_q, cnt_d;
   logic [1:0]          press_q, press_d;
   logic [2:0]          vel_q, vel_d;
   logic                sat_q, sat_d;
   logic [21:0]         presc_q, presc_d;
   logic [2:0]          sub_q, sub_d;
   logic                tick_q, tick_d;

   assign key_raw = {KEY_INC_N, KEY_DEC_N};

   // The sample that moves the FSM out of RELEASED/PRESSED already counts
   // as the first stable sample, hence the counter is loaded with 1 there.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         st_d[k]    = st_q[k];
         cnt_d[k]   = cnt_q[k];
         press_d[k] = 1'b0;
         case (st_q[k])
            ST_RELEASED: begin
               if (!sync2_q[k]) begin
                  st_d[k]  = ST_PRESS_WAIT;
                  cnt_d[k] = CW'(1);
               end
            end
            ST_PRESS_WAIT: begin
               if (sync2_q[k]) begin
                  st_d[k]  = ST_RELEASED;
                  cnt_d[k] = '0;
               end else if (cnt_q[k] == DEB_LAST) begin
                  st_d[k]    = ST_PRESSED;
                  cnt_d[k]   = '0;
                  press_d[k] = 1'b1;
               end else begin
                  cnt_d[k] = cnt_q[k] + CW'(1);
               end
            end
            ST_PRESSED: begin
               if (sync2_q[k]) begin
                  st_d[k]  = ST_RELEASE_WAIT;
                  cnt_d[k] = CW'(1);
               end
            end
            ST_RELEASE_WAIT: begin
               if (!sync2_q[k]) begin
                  st_d[k]  = ST_PRESSED;
                  cnt_d[k] = '0;
               end else if (cnt_q[k] == DEB_LAST) begin
                  st_d[k]  = ST_RELEASED;
                  cnt_d[k] = '0;
               end else begin
                  cnt_d[k] = cnt_q[k] + CW'(1);
               end
            end
            default: begin
               st_d[k]  = ST_RELEASED;
               cnt_d[k] = '0;
            end
         endcase
      end
   end

   // Simultaneous presses cancel each other and never flag a limit.
   always_comb begin
      vel_d = vel_q;
      sat_d = 1'b0;
      if (press_q[1] && !press_q[0]) begin
`ifdef CTRL_VEL_WRAP_EN
         vel_d = vel_q + 3'd1;
`else
         if (vel_q == 3'd7) sat_d = 1'b1;
         else               vel_d = vel_q + 3'd1;
`endif
      end else if (press_q[0] && !press_q[1]) begin
`ifdef CTRL_VEL_WRAP_EN
         vel_d = vel_q - 3'd1;
`else
         if (vel_q == 3'd0) sat_d = 1'b1;
         else               vel_d = vel_q - 3'd1;
`endif
      end
   end

   // Using >= lets a speed increase mid-period fire on the next sub-tick
   // instead of waiting for the sub-tick counter to wrap.
   always_comb begin
      presc_d = presc_q;
      sub_d   = sub_q;
      tick_d  = 1'b0;
      if (!EN) begin
         presc_d = '0;
         sub_d   = '0;
      end else if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         if (sub_q >= (3'd7 - vel_q)) begin
            sub_d  = '0;
            tick_d = 1'b1;
         end else begin
            sub_d = sub_q + 3'd1;
         end
      end else begin
         presc_d = presc_q + 22'd1;
      end
   end

   always_ff @(posedge CLK_50) begin
      if (RST) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         st_q    <= {ST_RELEASED, ST_RELEASED};
         cnt_q   <= '0;
         press_q <= 2'b00;
         vel_q   <= VEL_INIT;
         sat_q   <= 1'b0;
         presc_q <= '0;
         sub_q   <= '0;
         tick_q  <= 1'b0;
      end else begin
         sync1_q <= key_raw;
         sync2_q <= sync1_q;
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
         vel_q   <= vel_d;
         sat_q   <= sat_d;
         presc_q <= presc_d;
         sub_q   <= sub_d;
         tick_q  <= tick_d;
      end
   end

   assign VEL       = vel_q;
   assign TICK      = tick_q;
   assign PRESS_DEC = press_q[0];
   assign PRESS_INC = press_q[1];
   assign SAT       = sat_q;

endmodule

// File: tb/tb_control_velocidad_teclas.sv
// tb/tb_control_velocidad_teclas.sv - directed self-checking bench for control_velocidad_teclas
module tb_control_velocidad_teclas;

   logic       CLK_50 = 1'b0;
   logic       RST = 1'b1;
   logic       EN = 1'b1;
   logic       KEY_DEC_N = 1'b1;
   logic       KEY_INC_N = 1'b1;
   logic [2:0] VEL;
   logic       TICK;
   logic       PRESS_DEC;
   logic       PRESS_INC;
   logic       SAT;

   int checks = 0;
   int errors = 0;
   int n_inc = 0, n_dec = 0, n_sat = 0, n_tick = 0, n_both = 0;

`ifdef CTRL_VEL_WRAP_EN
   localparam int LAST_VEL = 0;
   localparam int LAST_SAT = 0;
`else
   localparam int LAST_VEL = 7;
   localparam int LAST_SAT = 1;
`endif

   control_velocidad_teclas #(
      .DEB_CYCLES(4),
      .BASE_DIV  (2),
      .VEL_INIT  (3'd3)
   ) dut (
      .CLK_50   (CLK_50),
      .RST      (RST),
      .EN       (EN),
      .KEY_DEC_N(KEY_DEC_N),
      .KEY_INC_N(KEY_INC_N),
      .VEL      (VEL),
      .TICK     (TICK),
      .PRESS_DEC(PRESS_DEC),
      .PRESS_INC(PRESS_INC),
      .SAT      (SAT)
   );

   always #5 CLK_50 = ~CLK_50;

   always @(negedge CLK_50) begin
      n_inc  += int'(PRESS_INC);
      n_dec  += int'(PRESS_DEC);
      n_sat  += int'(SAT);
      n_tick += int'(TICK);
      n_both += int'(PRESS_INC && PRESS_DEC);
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK_50);
      #1;
   endtask

   task automatic wait_tick(output int n);
      n = -1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge CLK_50);
         if (TICK) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic press(input logic inc, input logic dec);
      KEY_INC_N = !inc;
      KEY_DEC_N = !dec;
      idle(8);
      KEY_INC_N = 1'b1;
      KEY_DEC_N = 1'b1;
      idle(8);
   endtask

   initial begin
      int n, lat, s0, i0, d0, b0, t0;
      int exp_vel[5];
      exp_vel = '{4, 5, 6, 7, LAST_VEL};

      // reset state
      repeat (3) @(negedge CLK_50);
      check("rst_vel", int'(VEL), 3);
      check("rst_tick", int'(TICK), 0);
      check("rst_press_inc", int'(PRESS_INC), 0);
      check("rst_press_dec", int'(PRESS_DEC), 0);
      check("rst_sat", int'(SAT), 0);
      RST = 1'b0;

      // idle tick period at VEL=3: 2*(8-3)
      wait_tick(n);
      wait_tick(n);
      check("period_vel3", n, 10);
      check("idle_vel", int'(VEL), 3);

      // single held increment: latency, single pulse, new period
      idle(1);
      i0 = n_inc;
      lat = -1;
      KEY_INC_N = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK_50);
         if (PRESS_INC && lat < 0) lat = i;
      end
      KEY_INC_N = 1'b1;
      idle(10);
      check("inc_latency", lat, 5);
      check("inc_pulses", n_inc - i0, 1);
      check("inc_vel", int'(VEL), 4);
      wait_tick(n);
      wait_tick(n);
      check("period_vel4", n, 8);

      // bouncing decrement never accepted
      idle(1);
      d0 = n_dec;
      KEY_DEC_N = 1'b0; idle(2);
      KEY_DEC_N = 1'b1; idle(1);
      KEY_DEC_N = 1'b0; idle(2);
      KEY_DEC_N = 1'b1; idle(15);
      check("bounce_pulses", n_dec - d0, 0);
      check("bounce_vel", int'(VEL), 4);

      // five increments from 3 reach the upper limit
      RST = 1'b1; idle(2);
      RST = 1'b0; idle(1);
      check("rst2_vel", int'(VEL), 3);
      for (int i = 0; i < 5; i++) begin
         s0 = n_sat;
         press(1'b1, 1'b0);
         check($sformatf("inc%0d_vel", i), int'(VEL), exp_vel[i]);
         check($sformatf("inc%0d_sat", i), n_sat - s0, (i == 4) ? LAST_SAT : 0);
      end

      // simultaneous presses cancel
      s0 = n_sat; i0 = n_inc; d0 = n_dec; b0 = n_both;
      press(1'b1, 1'b1);
      check("both_coincide", n_both - b0, 1);
      check("both_inc", n_inc - i0, 1);
      check("both_dec", n_dec - d0, 1);
      check("both_vel", int'(VEL), LAST_VEL);
      check("both_sat", n_sat - s0, 0);

      // EN=0 holds ticks off while keys still work
      EN = 1'b0;
      RST = 1'b1; idle(2);
      RST = 1'b0; idle(2);
      t0 = n_tick;
      press(1'b1, 1'b0);
      idle(14);
      check("en0_ticks", n_tick - t0, 0);
      check("en0_tick_level", int'(TICK), 0);
      check("en0_vel", int'(VEL), 4);
      EN = 1'b1;
      wait_tick(n);
      check("en_first_tick", n, 8);

      // reset during PRESS_WAIT aborts the press
      idle(1);
      KEY_INC_N = 1'b0;
      idle(3);
      i0 = n_inc;
      RST = 1'b1;
      KEY_INC_N = 1'b1;
      idle(1);
      RST = 1'b0;
      idle(15);
      check("rst_mid_pulses", n_inc - i0, 0);
      check("rst_mid_vel", int'(VEL), 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
